// File: rtl/map_req_if.sv
// Request/response and map-memory bundle shared by the game agents and map_req_arbiter.
// master = agents plus the memory model, slave = the arbiter.
interface map_req_if #(
  parameter int N_REQ  = 4,
  parameter int ADDR_W = 8
);
  logic [N_REQ-1:0]        req;
  logic [2*N_REQ-1:0]      req_type;
  logic [ADDR_W*N_REQ-1:0] req_content;
  logic [N_REQ-1:0]        ACK;
  logic [N_REQ-1:0]        NACK;
  logic [N_REQ-1:0]        wr;
  logic [15:0]             data_out;
  logic [ADDR_W-1:0]       mem_addr;
  logic                    mem_rd_en;
  logic                    mem_wr_en;
  logic [15:0]             mem_wdata;
  logic [15:0]             mem_rdata;

  modport master (
    output req, req_type, req_content, mem_rdata,
    input  ACK, NACK, wr, data_out, mem_addr, mem_rd_en, mem_wr_en, mem_wdata
  );

  modport slave (
    input  req, req_type, req_content, mem_rdata,
    output ACK, NACK, wr, data_out, mem_addr, mem_rd_en, mem_wr_en, mem_wdata
  );
endinterface

// File: rtl/map_req_arbiter.sv
// Round-robin arbiter granting atomic read/claim/release access to the 256x16 map memory.
// Optional macro ARB_DIGGER_PRIO_EN gives requester 0 (digger) absolute priority.
module map_req_arbiter #(
  parameter int N_REQ  = 4,
  parameter int ADDR_W = 8
) (
  input logic      clk,
  input logic      rst,
  map_req_if.slave bus
);

  typedef enum logic [2:0] {IDLE, RD, WAIT, RESP, GAP} state_t;

  state_t            state_r, state_s;
  logic [2:0]        ptr_r, ptr_s;
  logic [2:0]        g_r, g_s;
  logic [1:0]        type_r, type_s;
  logic [ADDR_W-1:0] addr_r, addr_s;
  logic [15:0]       w_r, w_s;
  logic [N_REQ-1:0]  ack_r, ack_s, nack_r, nack_s, wr_r, wr_s;
  logic [15:0]       data_r, data_s, wdata_r, wdata_s;
  logic              rd_en_r, rd_en_s, wr_en_r, wr_en_s;

  logic              found_s, hi_found_s;
  logic [2:0]        win_s, hi_win_s, lo_win_s;
  logic [1:0]        sel_type_s;
  logic [ADDR_W-1:0] sel_cont_s;
  logic [N_REQ-1:0]  g_mask_s;
  logic [2:0]        ptr_next_s;

  // Winner selection: first requester at or above the pointer, otherwise the lowest one (wrap).
  always_comb begin
    hi_found_s = 1'b0;
    hi_win_s   = 3'd0;
    lo_win_s   = 3'd0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      lo_win_s   = bus.req[i] ? 3'(i) : lo_win_s;
      hi_win_s   = (bus.req[i] && (i >= int'(ptr_r))) ? 3'(i) : hi_win_s;
      hi_found_s = hi_found_s | (bus.req[i] && (i >= int'(ptr_r)));
    end
    found_s = |bus.req;
`ifdef ARB_DIGGER_PRIO_EN
    if (bus.req[0]) begin
      win_s = 3'd0;
    end else if (hi_found_s) begin
      win_s = hi_win_s;
    end else begin
      win_s = lo_win_s;
    end
`else
    if (hi_found_s) begin
      win_s = hi_win_s;
    end else begin
      win_s = lo_win_s;
    end
`endif
    sel_type_s = 2'b00;
    sel_cont_s = {ADDR_W{1'b0}};
    for (int i = 0; i < N_REQ; i++) begin
      sel_type_s = (3'(i) == win_s) ? bus.req_type[2*i +: 2] : sel_type_s;
      sel_cont_s = (3'(i) == win_s) ? bus.req_content[ADDR_W*i +: ADDR_W] : sel_cont_s;
    end
  end

  // Grant mask and the pointer value that follows the current grant.
  always_comb begin
    g_mask_s = {{(N_REQ-1){1'b0}}, 1'b1} << g_r;
    if (int'(g_r) == N_REQ - 1) begin
      ptr_next_s = 3'd0;
    end else begin
      ptr_next_s = g_r + 3'd1;
    end
  end

  // Next-state and next-output logic; the response is decided in WAIT so it can be registered into RESP.
  always_comb begin
    state_s = state_r;
    ptr_s   = ptr_r;
    g_s     = g_r;
    type_s  = type_r;
    addr_s  = addr_r;
    w_s     = w_r;
    ack_s   = {N_REQ{1'b0}};
    nack_s  = {N_REQ{1'b0}};
    wr_s    = {N_REQ{1'b0}};
    data_s  = data_r;
    wdata_s = wdata_r;
    rd_en_s = 1'b0;
    wr_en_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (found_s) begin
          g_s     = win_s;
          type_s  = sel_type_s;
          addr_s  = sel_cont_s;
          rd_en_s = 1'b1;
          state_s = RD;
        end else begin
          state_s = IDLE;
        end
      end
      RD: begin
        state_s = WAIT;
      end
      WAIT: begin
        w_s     = bus.mem_rdata;
        state_s = RESP;
`ifdef ARB_DIGGER_PRIO_EN
        if (g_r != 3'd0) begin
          ptr_s = ptr_next_s;
        end else begin
          ptr_s = ptr_r;
        end
`else
        ptr_s = ptr_next_s;
`endif
        case (type_r)
          2'b00: begin
            ack_s  = g_mask_s;
            wr_s   = g_mask_s;
            data_s = bus.mem_rdata;
          end
          2'b01: begin
            if (!bus.mem_rdata[15]) begin
              wdata_s = {1'b1, g_r, bus.mem_rdata[11:0]};
              data_s  = {1'b1, g_r, bus.mem_rdata[11:0]};
              wr_en_s = 1'b1;
              ack_s   = g_mask_s;
            end else begin
              data_s = bus.mem_rdata;
              nack_s = g_mask_s;
            end
          end
          2'b10: begin
            if (bus.mem_rdata[15] && (bus.mem_rdata[14:12] == g_r)) begin
              wdata_s = {1'b0, 3'b000, bus.mem_rdata[11:0]};
              wr_en_s = 1'b1;
              ack_s   = g_mask_s;
            end else begin
              nack_s = g_mask_s;
            end
          end
          default: begin
            nack_s = g_mask_s;
          end
        endcase
      end
      RESP: begin
        state_s = GAP;
      end
      GAP: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State, grant context and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      ptr_r   <= 3'd0;
      g_r     <= 3'd0;
      type_r  <= 2'b00;
      addr_r  <= {ADDR_W{1'b0}};
      w_r     <= 16'h0000;
      ack_r   <= {N_REQ{1'b0}};
      nack_r  <= {N_REQ{1'b0}};
      wr_r    <= {N_REQ{1'b0}};
      data_r  <= 16'h0000;
      wdata_r <= 16'h0000;
      rd_en_r <= 1'b0;
      wr_en_r <= 1'b0;
    end else begin
      state_r <= state_s;
      ptr_r   <= ptr_s;
      g_r     <= g_s;
      type_r  <= type_s;
      addr_r  <= addr_s;
      w_r     <= w_s;
      ack_r   <= ack_s;
      nack_r  <= nack_s;
      wr_r    <= wr_s;
      data_r  <= data_s;
      wdata_r <= wdata_s;
      rd_en_r <= rd_en_s;
      wr_en_r <= wr_en_s;
    end
  end

  assign bus.ACK       = ack_r;
  assign bus.NACK      = nack_r;
  assign bus.wr        = wr_r;
  assign bus.data_out  = data_r;
  assign bus.mem_addr  = addr_r;
  assign bus.mem_rd_en = rd_en_r;
  assign bus.mem_wr_en = wr_en_r;
  assign bus.mem_wdata = wdata_r;

endmodule

// File: tb/tb_map_req_arbiter.sv
// Directed bench for map_req_arbiter: read, claim/conflict, contention, release, reserved type, reset mid-claim.
module tb_map_req_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  map_req_if #(.N_REQ(4), .ADDR_W(8)) bus();

  map_req_arbiter #(.N_REQ(4), .ADDR_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  logic [15:0] mem [0:255];
  int          wr_count = 0;
  logic        poke_en = 1'b0;
  logic [7:0]  poke_addr = 8'h00;
  logic [15:0] poke_data = 16'h0000;

  // Synchronous map memory with a backdoor preload port.
  always @(posedge clk) begin
    if (poke_en) mem[poke_addr] <= poke_data;
    if (bus.mem_wr_en) begin
      mem[bus.mem_addr] <= bus.mem_wdata;
      wr_count <= wr_count + 1;
    end
    if (bus.mem_rd_en) bus.mem_rdata <= mem[bus.mem_addr];
  end

  task automatic poke(input logic [7:0] a, input logic [15:0] d);
    @(negedge clk);
    poke_en = 1'b1; poke_addr = a; poke_data = d;
    @(negedge clk);
    poke_en = 1'b0;
  endtask

  task automatic issue(input int i, input logic [1:0] t, input logic [7:0] c);
    bus.req[i] = 1'b1;
    bus.req_type[2*i +: 2] = t;
    bus.req_content[8*i +: 8] = c;
  endtask

  task automatic wait_resp(input int budget, output int cyc, output int who, output bit seen);
    seen = 1'b0; cyc = 0; who = -1;
    while (!seen && cyc < budget) begin
      @(negedge clk);
      cyc++;
      if (|(bus.ACK | bus.NACK)) seen = 1'b1;
    end
    if (seen) for (int i = 0; i < 4; i++) if (bus.ACK[i] | bus.NACK[i]) who = i;
  endtask

  task automatic drop_and_idle();
    bus.req = 4'b0000;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    bus.req = 4'b0000; bus.req_type = 8'h00; bus.req_content = 32'h0;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.ACK, bus.NACK, bus.wr, bus.data_out, bus.mem_addr, bus.mem_rd_en, bus.mem_wr_en, bus.mem_wdata} !== 62'h0) begin
      errors++; $display("FAIL reset_outputs: got ACK=%b NACK=%b wr=%b data=%h addr=%h expected all 0",
                         bus.ACK, bus.NACK, bus.wr, bus.data_out, bus.mem_addr);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.mem_rd_en !== 1'b0) begin
      errors++; $display("FAIL idle_no_req: mem_rd_en=%b expected 0", bus.mem_rd_en);
    end
  endtask

  task automatic test_read();
    int cyc, who, w0; bit seen;
    poke(8'h24, 16'h0123);
    w0 = wr_count;
    issue(1, 2'b00, 8'h24);
    wait_resp(10, cyc, who, seen);
    checks++;
    if (!seen || cyc != 3) begin
      errors++; $display("FAIL read_latency: got %0d cycles (seen=%0d) expected 3", cyc, seen);
    end
    checks++;
    if (bus.ACK !== 4'b0010 || bus.wr !== 4'b0010 || bus.NACK !== 4'b0000) begin
      errors++; $display("FAIL read_ack: ACK=%b wr=%b NACK=%b expected 0010 0010 0000", bus.ACK, bus.wr, bus.NACK);
    end
    checks++;
    if (bus.data_out !== 16'h0123) begin
      errors++; $display("FAIL read_data: got %h expected 0123", bus.data_out);
    end
    drop_and_idle();
    checks++;
    if (bus.ACK !== 4'b0000 || bus.wr !== 4'b0000 || wr_count != w0) begin
      errors++; $display("FAIL read_pulse_nowrite: ACK=%b wr=%b writes=%0d expected 0000 0000 0", bus.ACK, bus.wr, wr_count - w0);
    end
  endtask

  task automatic test_claim();
    int cyc, who, w0; bit seen;
    poke(8'h4F, 16'h0005);
    issue(2, 2'b01, 8'h4F);
    wait_resp(10, cyc, who, seen);
    checks++;
    if (bus.ACK !== 4'b0100 || bus.NACK !== 4'b0000 || bus.data_out !== 16'hA005) begin
      errors++; $display("FAIL claim_ack: ACK=%b NACK=%b data=%h expected 0100 0000 a005", bus.ACK, bus.NACK, bus.data_out);
    end
    drop_and_idle();
    checks++;
    if (mem[8'h4F] !== 16'hA005) begin
      errors++; $display("FAIL claim_mem: got %h expected a005", mem[8'h4F]);
    end
    w0 = wr_count;
    issue(3, 2'b01, 8'h4F);
    wait_resp(10, cyc, who, seen);
    checks++;
    if (bus.NACK !== 4'b1000 || bus.ACK !== 4'b0000 || bus.data_out !== 16'hA005) begin
      errors++; $display("FAIL claim_conflict: ACK=%b NACK=%b data=%h expected 0000 1000 a005", bus.ACK, bus.NACK, bus.data_out);
    end
    drop_and_idle();
    checks++;
    if (mem[8'h4F] !== 16'hA005 || wr_count != w0) begin
      errors++; $display("FAIL conflict_mem: got %h writes=%0d expected a005 0", mem[8'h4F], wr_count - w0);
    end
  endtask

  task automatic test_contention();
    int cyc, who; bit seen;
`ifdef ARB_DIGGER_PRIO_EN
    int exp_order [5] = '{0, 0, 0, 0, 0};
`else
    int exp_order [5] = '{0, 1, 2, 3, 0};
`endif
    for (int i = 0; i < 4; i++) issue(i, 2'b00, 8'h24);
    for (int k = 0; k < 5; k++) begin
      wait_resp(12, cyc, who, seen);
      checks++;
      if (who != exp_order[k]) begin
        errors++; $display("FAIL contention_order[%0d]: got %0d expected %0d", k, who, exp_order[k]);
      end
      checks++;
      if (cyc != ((k == 0) ? 3 : 5)) begin
        errors++; $display("FAIL contention_spacing[%0d]: got %0d expected %0d", k, cyc, (k == 0) ? 3 : 5);
      end
    end
    drop_and_idle();
  endtask

  task automatic test_release();
    int cyc, who, w0; bit seen;
    w0 = wr_count;
    issue(3, 2'b10, 8'h4F);
    wait_resp(10, cyc, who, seen);
    checks++;
    if (bus.NACK !== 4'b1000 || bus.ACK !== 4'b0000) begin
      errors++; $display("FAIL release_foreign: ACK=%b NACK=%b expected 0000 1000", bus.ACK, bus.NACK);
    end
    drop_and_idle();
    checks++;
    if (mem[8'h4F] !== 16'hA005 || wr_count != w0) begin
      errors++; $display("FAIL release_foreign_mem: got %h writes=%0d expected a005 0", mem[8'h4F], wr_count - w0);
    end
    issue(2, 2'b10, 8'h4F);
    wait_resp(10, cyc, who, seen);
    checks++;
    if (bus.ACK !== 4'b0100 || bus.NACK !== 4'b0000) begin
      errors++; $display("FAIL release_owner: ACK=%b NACK=%b expected 0100 0000", bus.ACK, bus.NACK);
    end
    drop_and_idle();
    checks++;
    if (mem[8'h4F] !== 16'h0005) begin
      errors++; $display("FAIL release_mem: got %h expected 0005", mem[8'h4F]);
    end
  endtask

  task automatic test_reserved();
    int cyc, who, w0; bit seen;
    w0 = wr_count;
    issue(0, 2'b11, 8'h24);
    wait_resp(10, cyc, who, seen);
    checks++;
    if (bus.NACK !== 4'b0001 || bus.ACK !== 4'b0000 || bus.wr !== 4'b0000) begin
      errors++; $display("FAIL reserved_resp: ACK=%b NACK=%b wr=%b expected 0000 0001 0000", bus.ACK, bus.NACK, bus.wr);
    end
    drop_and_idle();
    checks++;
    if (wr_count != w0 || mem[8'h24] !== 16'h0123) begin
      errors++; $display("FAIL reserved_nowrite: writes=%0d cell=%h expected 0 0123", wr_count - w0, mem[8'h24]);
    end
  endtask

  task automatic test_reset_mid_claim();
    int cyc, who, w0; bit seen;
    poke(8'h10, 16'h0007);
    w0 = wr_count;
    issue(2, 2'b01, 8'h10);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if ({bus.ACK, bus.NACK, bus.wr, bus.data_out, bus.mem_addr, bus.mem_rd_en, bus.mem_wr_en, bus.mem_wdata} !== 62'h0) begin
      errors++; $display("FAIL midreset_outputs: ACK=%b NACK=%b data=%h addr=%h expected all 0",
                         bus.ACK, bus.NACK, bus.data_out, bus.mem_addr);
    end
    bus.req = 4'b0000;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (mem[8'h10] !== 16'h0007 || wr_count != w0) begin
      errors++; $display("FAIL midreset_mem: got %h writes=%0d expected 0007 0", mem[8'h10], wr_count - w0);
    end
    issue(0, 2'b00, 8'h24);
    issue(2, 2'b00, 8'h24);
    wait_resp(10, cyc, who, seen);
    checks++;
    if (who != 0 || bus.ACK !== 4'b0001) begin
      errors++; $display("FAIL midreset_pointer: grant=%0d ACK=%b expected 0 0001", who, bus.ACK);
    end
    drop_and_idle();
  endtask

  initial begin
    test_reset();
    test_read();
    test_claim();
    test_contention();
    test_release();
    test_reserved();
    test_reset_mid_claim();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
